// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: cascaded x/y counters with
// registered sync, data-enable and line/frame strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_bad_len
    $error("vga_timing_gen: zero-length timing field");
  end

  if (CW < 1 || CW > 30 ||
      (2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL)
  begin : g_bad_cw
    $error("vga_timing_gen: CW too small for totals");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DE   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_DE   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_HS0  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_HS1  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_VS0  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_VS1  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          x_wrap;
  logic          y_wrap;
  logic [CW-1:0] x_nx;
  logic [CW-1:0] y_nx;
  logic          de_nx;
  logic          hs_nx;
  logic          vs_nx;
  logic          ls_nx;
  logic          fs_nx;

  // >= rather than == so an upset counter falls back to 0
  always_comb begin
    x_wrap = (x >= H_LAST);
    y_wrap = (y >= V_LAST);
    x_nx   = x_wrap ? '0 : x + CW'(1);
    y_nx   = y;
    if (x_wrap) begin
      y_nx = y_wrap ? '0 : y + CW'(1);
    end
    de_nx = (x_nx < H_DE) && (y_nx < V_DE);
    hs_nx = ((x_nx >= H_HS0) && (x_nx < H_HS1)) ? H_POL : ~H_POL;
    vs_nx = ((y_nx >= V_VS0) && (y_nx < V_VS1)) ? V_POL : ~V_POL;
    ls_nx = (x_nx == '0);
    fs_nx = ls_nx && (y_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (cen) begin
      x           <= x_nx;
      y           <= y_nx;
      de          <= de_nx;
      hsync       <= hs_nx;
      vsync       <= vs_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, short-frame
// and tiny configurations against a linear pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;

  always #5 clk = ~clk;

  localparam int HA [3] = '{640, 640, 4};
  localparam int HF [3] = '{16, 16, 1};
  localparam int HS [3] = '{96, 96, 1};
  localparam int HB [3] = '{48, 48, 1};
  localparam int VA [3] = '{480, 4, 3};
  localparam int VF [3] = '{10, 2, 1};
  localparam int VS [3] = '{2, 2, 1};
  localparam int VB [3] = '{33, 3, 1};
  localparam bit HP [3] = '{1'b0, 1'b0, 1'b1};
  localparam bit VP [3] = '{1'b0, 1'b0, 1'b1};

  logic [9:0] def_x, def_y, mid_x, mid_y;
  logic [3:0] sml_x, sml_y;
  logic def_de, def_hs, def_vs, def_ls, def_fs;
  logic mid_de, mid_hs, mid_vs, mid_ls, mid_fs;
  logic sml_de, sml_hs, sml_vs, sml_ls, sml_fs;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .cen(cen),
    .x(def_x), .y(def_y), .de(def_de),
    .hsync(def_hs), .vsync(def_vs),
    .line_start(def_ls), .frame_start(def_fs)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_mid (
    .clk(clk), .rst(rst), .cen(cen),
    .x(mid_x), .y(mid_y), .de(mid_de),
    .hsync(mid_hs), .vsync(mid_vs),
    .line_start(mid_ls), .frame_start(mid_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) u_sml (
    .clk(clk), .rst(rst), .cen(cen),
    .x(sml_x), .y(sml_y), .de(sml_de),
    .hsync(sml_hs), .vsync(sml_vs),
    .line_start(sml_ls), .frame_start(sml_fs)
  );

  int checks = 0;
  int failures = 0;
  int p [3] = '{0, 0, 0};
  bit m_ls [3] = '{0, 0, 0};
  bit m_fs [3] = '{0, 0, 0};

  function automatic logic [31:0] pk(int xx, int yy,
    bit d, bit h, bit v, bit l, bit f);
    logic [11:0] xa;
    logic [11:0] ya;
    xa = xx[11:0];
    ya = yy[11:0];
    return {xa, ya, 3'b000, d, h, v, l, f};
  endfunction

  function automatic int ht(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic logic [31:0] expv(int i);
    int xx, yy;
    bit d, h, v;
    xx = p[i] % ht(i);
    yy = p[i] / ht(i);
    d = (xx < HA[i]) && (yy < VA[i]);
    h = (xx >= HA[i] + HF[i]) && (xx < HA[i] + HF[i] + HS[i]);
    v = (yy >= VA[i] + VF[i]) && (yy < VA[i] + VF[i] + VS[i]);
    return pk(xx, yy, d, h ? HP[i] : !HP[i],
              v ? VP[i] : !VP[i], m_ls[i], m_fs[i]);
  endfunction

  function automatic logic [31:0] actv(int i);
    case (i)
      0: return pk(int'(def_x), int'(def_y), def_de, def_hs,
                   def_vs, def_ls, def_fs);
      1: return pk(int'(mid_x), int'(mid_y), mid_de, mid_hs,
                   mid_vs, mid_ls, mid_fs);
      default: return pk(int'(sml_x), int'(sml_y), sml_de,
                   sml_hs, sml_vs, sml_ls, sml_fs);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit c);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        p[i] = ht(i) * vt(i) - 1;
        m_ls[i] = 0;
        m_fs[i] = 0;
      end else if (c) begin
        p[i] = (p[i] + 1) % (ht(i) * vt(i));
        m_ls[i] = (p[i] % ht(i)) == 0;
        m_fs[i] = (p[i] == 0);
      end else begin
        m_ls[i] = 0;
        m_fs[i] = 0;
      end
    end
  endtask

  task automatic tick(bit r, bit c);
    rst = r;
    cen = c;
    @(posedge clk);
    #1;
    model_step(r, c);
    for (int i = 0; i < 3; i++)
      check($sformatf("model_%0d", i), actv(i), expv(i));
  endtask

  typedef struct {
    bit r; bit c;
    int x; int y;
    bit de; bit hs; bit vs; bit ls; bit fs;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int ls1, ls2, fs1, fs2, sf1, sf2;
    int hlow, hfirst, defall;
    bit r;
    tbl[0]  = '{1, 1, 6, 5, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 6, 5, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 2, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 3, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 4, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 5, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 5, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 6, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
    tbl[12] = '{1, 1, 6, 5, 0, 0, 0, 0, 0};

    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      tick(tbl[k].r, tbl[k].c);
      check($sformatf("tbl_%0d", k),
            pk(int'(sml_x), int'(sml_y), sml_de, sml_hs,
               sml_vs, sml_ls, sml_fs),
            pk(tbl[k].x, tbl[k].y, tbl[k].de, tbl[k].hs,
               tbl[k].vs, tbl[k].ls, tbl[k].fs));
      if (k == 2)
        check("first_def",
              pk(int'(def_x), int'(def_y), def_de, def_hs,
                 def_vs, def_ls, def_fs),
              pk(0, 0, 1, 1, 1, 1, 1));
    end

    tick(1, 0);
    ls1 = -1; ls2 = -1; fs1 = -1; fs2 = -1;
    sf1 = -1; sf2 = -1;
    hlow = 0; hfirst = -1; defall = -1;
    for (int n = 1; n <= 20000 && fs2 < 0; n++) begin
      tick(0, 1);
      if (def_ls) begin
        if (ls1 < 0) ls1 = n;
        else if (ls2 < 0) ls2 = n;
      end
      if (mid_fs) begin
        if (fs1 < 0) fs1 = n;
        else fs2 = n;
      end
      if (sml_fs) begin
        if (sf1 < 0) sf1 = n;
        else if (sf2 < 0) sf2 = n;
      end
      if (n <= 800 && !def_hs) begin
        hlow++;
        if (hfirst < 0) hfirst = int'(def_x);
      end
      if (n <= 800 && !def_de && defall < 0)
        defall = int'(def_x);
    end
    check("line_period", ls2 - ls1, 800);
    check("mid_frame_period", fs2 - fs1, 8800);
    check("sml_frame_period", sf2 - sf1, 42);
    check("hsync_width", hlow, 96);
    check("hsync_first_x", hfirst, 656);
    check("de_fall_x", defall, 640);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(399) == 0);
      tick(r, 1'($urandom));
    end

    for (int n = 0; n < 900; n++)
      tick(0, (n % 3) == 0);

    tick(1, 1);
    check("mid_reset",
          pk(int'(def_x), int'(def_y), def_de, def_hs,
             def_vs, def_ls, def_fs),
          pk(799, 524, 0, 1, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
